// File: rtl/crc32_pkg.sv
// -----------------------------------------------------------------------------
// crc32_pkg
// Constants and types shared by the CRC-32 transmit generator and the
// receive-side checker (crc32_frame_rx).
//   CRC_POLY : generator polynomial without the implicit x^32 term
//   MSG_W    : message bits per frame
//   CRC_W    : CRC bits per frame
//   FRAME_W  : total serial frame length
//   rx_state_e : receiver FSM states
//   crc32_step : one plain bit-serial division step (no init, no reflection,
//                no final XOR)
// No ports (package).
// -----------------------------------------------------------------------------
package crc32_pkg;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam int          MSG_W    = 8;
    localparam int          CRC_W    = 32;
    localparam int          FRAME_W  = MSG_W + CRC_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

    // Feed one message bit into the division register, MSB-first.
    function automatic logic [31:0] crc32_step(input logic [31:0] lfsr,
                                               input logic        din);
        logic fb;
        fb = lfsr[31] ^ din;
        return {lfsr[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/crc32_frame_rx_if.sv
// -----------------------------------------------------------------------------
// crc32_frame_rx_if
// Bundles the serial input stream and the checked-frame outputs of
// crc32_frame_rx.
//   master : frame source / consumer (drives bit_in, bit_vld, sof)
//   slave  : the receiver (drives busy, frame_vld, msg_out, crc_rx, crc_ok,
//            crc_err, abort)
// When CRC32_FRAME_RX_ERRCNT_EN is defined, err_cnt and abort_cnt are added
// as receiver outputs.
// -----------------------------------------------------------------------------
interface crc32_frame_rx_if #(
    parameter int MSG_W = crc32_pkg::MSG_W,
    parameter int CRC_W = crc32_pkg::CRC_W
);
    logic             bit_in;
    logic             bit_vld;
    logic             sof;
    logic             busy;
    logic             frame_vld;
    logic [MSG_W-1:0] msg_out;
    logic [CRC_W-1:0] crc_rx;
    logic             crc_ok;
    logic             crc_err;
    logic             abort;
`ifdef CRC32_FRAME_RX_ERRCNT_EN
    logic [15:0]      err_cnt;
    logic [15:0]      abort_cnt;

    modport master (
        output bit_in, bit_vld, sof,
        input  busy, frame_vld, msg_out, crc_rx, crc_ok, crc_err, abort,
        input  err_cnt, abort_cnt
    );

    modport slave (
        input  bit_in, bit_vld, sof,
        output busy, frame_vld, msg_out, crc_rx, crc_ok, crc_err, abort,
        output err_cnt, abort_cnt
    );
`else
    modport master (
        output bit_in, bit_vld, sof,
        input  busy, frame_vld, msg_out, crc_rx, crc_ok, crc_err, abort
    );

    modport slave (
        input  bit_in, bit_vld, sof,
        output busy, frame_vld, msg_out, crc_rx, crc_ok, crc_err, abort
    );
`endif
endinterface

// File: rtl/crc32_serial_lfsr.sv
// -----------------------------------------------------------------------------
// crc32_serial_lfsr
// Bit-serial CRC division register, MSB-first, plain polynomial division.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears the register
//   clr  : restart the division from zero (priority over en)
//   en   : shift din into the division this cycle
//   din  : serial data bit
//   lfsr : current division remainder
// clr together with en restarts from zero and consumes din in the same cycle,
// so a start-of-frame bit is never lost.
// -----------------------------------------------------------------------------
module crc32_serial_lfsr #(
    parameter int         W    = 32,
    parameter logic [W-1:0] POLY = crc32_pkg::CRC_POLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] lfsr
);
    import crc32_pkg::*;

    logic [W-1:0] lfsr_reg;
    logic [W-1:0] base;
    logic [W-1:0] stepped;
    logic         fb;

    // Remainder the step starts from: zero when restarting.
    assign base = clr ? '0 : lfsr_reg;
    assign fb   = base[W-1] ^ din;

    assign stepped[0] = fb & POLY[0];
    generate
        for (genvar gi = 1; gi < W; gi++) begin : g_step
            assign stepped[gi] = base[gi-1] ^ (fb & POLY[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= '0;
        end else if (en) begin
            lfsr_reg <= stepped;
        end else if (clr) begin
            lfsr_reg <= '0;
        end
    end

    assign lfsr = lfsr_reg;

endmodule

// File: rtl/crc32_frame_rx.sv
// -----------------------------------------------------------------------------
// crc32_frame_rx
// Receives an MSB-first serial frame {msg, crc}, recomputes the CRC bit by bit
// and reports the recovered message with a pass/fail verdict.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : crc32_frame_rx_if.slave
//          bit_in/bit_vld/sof    serial input, sof marks frame bit 0
//          busy                  a frame is partially received
//          frame_vld             1-cycle pulse, frame checked
//          msg_out/crc_rx        received fields, held until next frame_vld
//          crc_ok/crc_err        verdict, valid with frame_vld and held
//          abort                 1-cycle pulse, partial frame dropped by sof
// Optional: define CRC32_FRAME_RX_ERRCNT_EN to add saturating 16-bit
// err_cnt (failed frames) and abort_cnt (abort pulses) outputs.
// -----------------------------------------------------------------------------
module crc32_frame_rx #(
    parameter int               MSG_W = crc32_pkg::MSG_W,
    parameter int               CRC_W = crc32_pkg::CRC_W,
    parameter logic [CRC_W-1:0] POLY  = crc32_pkg::CRC_POLY
) (
    input  logic              clk,
    input  logic              rst,
    crc32_frame_rx_if.slave   bus
);
    import crc32_pkg::*;

    localparam int FRAME_W = MSG_W + CRC_W;
    localparam int CNT_W   = $clog2(FRAME_W);

    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_SHIFT = 1'(SHIFT);

    logic [0:0]         state_reg,     state_next;
    logic [CNT_W-1:0]   count_reg,     count_next;
    logic [FRAME_W-1:0] shift_reg,     shift_next;
    logic [MSG_W-1:0]   msg_out_reg,   msg_out_next;
    logic [CRC_W-1:0]   crc_rx_reg,    crc_rx_next;
    logic               frame_vld_reg, frame_vld_next;
    logic               abort_reg,     abort_next;
    logic               ok_hold_reg;
    logic               err_hold_reg;

    logic               start;
    logic               step;
    logic               last;
    logic               lfsr_en;
    logic [CRC_W-1:0]   lfsr;
    logic               lfsr_zero;

    // A valid sof always starts a frame, whatever the state.
    assign start   = bus.bit_vld & bus.sof;
    assign step    = bus.bit_vld & ~bus.sof & (state_reg == ST_SHIFT);
    assign last    = step & (count_reg == CNT_W'(FRAME_W - 1));
    assign lfsr_en = start | step;

    crc32_serial_lfsr #(
        .W    (CRC_W),
        .POLY (POLY)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .en   (lfsr_en),
        .din  (bus.bit_in),
        .lfsr (lfsr)
    );

    assign lfsr_zero = (lfsr == '0);

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        shift_next     = shift_reg;
        msg_out_next   = msg_out_reg;
        crc_rx_next    = crc_rx_reg;
        frame_vld_next = 1'b0;
        abort_next     = 1'b0;

        if (start) begin
            state_next = ST_SHIFT;
            count_next = CNT_W'(1);
            shift_next = {{(FRAME_W-1){1'b0}}, bus.bit_in};
            abort_next = (state_reg == ST_SHIFT);
        end else if (step) begin
            count_next = count_reg + CNT_W'(1);
            shift_next = {shift_reg[FRAME_W-2:0], bus.bit_in};
            if (last) begin
                state_next     = ST_IDLE;
                count_next     = '0;
                frame_vld_next = 1'b1;
                msg_out_next   = shift_next[FRAME_W-1 -: MSG_W];
                crc_rx_next    = shift_next[CRC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            shift_reg     <= '0;
            msg_out_reg   <= '0;
            crc_rx_reg    <= '0;
            frame_vld_reg <= 1'b0;
            abort_reg     <= 1'b0;
            ok_hold_reg   <= 1'b0;
            err_hold_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shift_reg     <= shift_next;
            msg_out_reg   <= msg_out_next;
            crc_rx_reg    <= crc_rx_next;
            frame_vld_reg <= frame_vld_next;
            abort_reg     <= abort_next;
            // The division register holds the final remainder only during the
            // frame_vld cycle; latch the verdict then so it survives the next
            // frame's bits.
            if (frame_vld_reg) begin
                ok_hold_reg  <= lfsr_zero;
                err_hold_reg <= ~lfsr_zero;
            end
        end
    end

    assign bus.busy      = (state_reg == ST_SHIFT);
    assign bus.frame_vld = frame_vld_reg;
    assign bus.abort     = abort_reg;
    assign bus.msg_out   = msg_out_reg;
    assign bus.crc_rx    = crc_rx_reg;
    // During frame_vld the remainder is read live; afterwards the held copy.
    assign bus.crc_ok    = frame_vld_reg ? lfsr_zero  : ok_hold_reg;
    assign bus.crc_err   = frame_vld_reg ? ~lfsr_zero : err_hold_reg;

`ifdef CRC32_FRAME_RX_ERRCNT_EN
    logic [15:0] err_cnt_reg;
    logic [15:0] abort_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg   <= '0;
            abort_cnt_reg <= '0;
        end else begin
            if (frame_vld_reg && !lfsr_zero && err_cnt_reg != 16'hFFFF) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
            if (abort_reg && abort_cnt_reg != 16'hFFFF) begin
                abort_cnt_reg <= abort_cnt_reg + 16'd1;
            end
        end
    end

    assign bus.err_cnt   = err_cnt_reg;
    assign bus.abort_cnt = abort_cnt_reg;
`endif

endmodule

// File: tb/tb_crc32_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_crc32_frame_rx
// Directed frames with hand-computed verdicts. The stimulus side pushes each
// expected frame_vld/abort event (with its due cycle) into a scoreboard queue;
// a monitor on the falling edge pops and compares whenever the receiver
// presents an event. Optional counters checked when
// CRC32_FRAME_RX_ERRCNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_crc32_frame_rx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    crc32_frame_rx_if bus ();

    crc32_frame_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_abort;
        logic [7:0]  msg;
        logic [31:0] crc;
        bit          ok;
        int          due;
    } exp_t;

    exp_t sb[$];

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    bit          in_frame = 1'b0;
    int          tb_cnt = 0;
    logic [39:0] tb_sh = '0;
    bit          cur_ok = 1'b0;
    int          exp_errcnt = 0;
    int          exp_abortcnt = 0;
    logic [7:0]  last_msg = '0;
    logic [31:0] last_crc = '0;
    bit          last_ok = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one valid bit for one cycle; record what the receiver must report.
    task automatic drive_bit(input logic b, input logic s);
        exp_t e;
        bus.bit_in  = b;
        bus.bit_vld = 1'b1;
        bus.sof     = s;
        if (s) begin
            if (in_frame) begin
                e.is_abort = 1'b1;
                e.msg      = '0;
                e.crc      = '0;
                e.ok       = 1'b0;
                e.due      = cyc + 1;
                sb.push_back(e);
                exp_abortcnt++;
                $display("stim: sof at frame bit %0d, abort expected", tb_cnt);
            end
            in_frame = 1'b1;
            tb_cnt   = 1;
            tb_sh    = {39'b0, b};
        end else if (in_frame) begin
            tb_sh  = {tb_sh[38:0], b};
            tb_cnt = tb_cnt + 1;
            if (tb_cnt == 40) begin
                e.is_abort = 1'b0;
                e.msg      = tb_sh[39:32];
                e.crc      = tb_sh[31:0];
                e.ok       = cur_ok;
                e.due      = cyc + 1;
                sb.push_back(e);
                if (!cur_ok) exp_errcnt++;
                last_msg = e.msg;
                last_crc = e.crc;
                last_ok  = cur_ok;
                in_frame = 1'b0;
                tb_cnt   = 0;
            end
        end
        @(posedge clk);
        #1;
        bus.bit_vld = 1'b0;
        bus.sof     = 1'b0;
        bus.bit_in  = 1'b0;
    endtask

    // Send the first nbits of frame f (sof on bit 0), optional random gaps.
    task automatic send(input logic [39:0] f, input bit ok, input int nbits, input int maxgap);
        cur_ok = ok;
        $display("stim: frame %h, %0d bits, max gap %0d, crc_ok expected %0d", f, nbits, maxgap, ok);
        for (int i = 0; i < nbits; i++) begin
            if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
            drive_bit(f[39-i], i == 0);
        end
    endtask

    // Monitor: pop and compare on every presented event.
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.frame_vld || bus.abort) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_event: frame_vld=%b abort=%b, expected none (cycle %0d)",
                         bus.frame_vld, bus.abort, cyc);
            end else begin
                e = sb.pop_front();
                chk("event_cycle", 40'(cyc), 40'(e.due));
                chk("abort", 40'(bus.abort), 40'(e.is_abort));
                chk("frame_vld", 40'(bus.frame_vld), 40'(!e.is_abort));
                if (!e.is_abort) begin
                    chk("msg_out", 40'(bus.msg_out), 40'(e.msg));
                    chk("crc_rx", 40'(bus.crc_rx), 40'(e.crc));
                    chk("crc_ok", 40'(bus.crc_ok), 40'(e.ok));
                    chk("crc_err", 40'(bus.crc_err), 40'(!e.ok));
                    $display("mon: frame msg=%h crc=%h crc_ok=%b crc_err=%b",
                             bus.msg_out, bus.crc_rx, bus.crc_ok, bus.crc_err);
                end else begin
                    $display("mon: abort at cycle %0d", cyc);
                end
            end
        end
    end

    task automatic chk_outputs_reset(input string tag);
        @(negedge clk);
        chk({tag, "_busy"},      40'(bus.busy),      40'(0));
        chk({tag, "_frame_vld"}, 40'(bus.frame_vld), 40'(0));
        chk({tag, "_abort"},     40'(bus.abort),     40'(0));
        chk({tag, "_msg_out"},   40'(bus.msg_out),   40'(0));
        chk({tag, "_crc_rx"},    40'(bus.crc_rx),    40'(0));
        chk({tag, "_crc_ok"},    40'(bus.crc_ok),    40'(0));
        chk({tag, "_crc_err"},   40'(bus.crc_err),   40'(0));
`ifdef CRC32_FRAME_RX_ERRCNT_EN
        chk({tag, "_err_cnt"},   40'(bus.err_cnt),   40'(0));
        chk({tag, "_abort_cnt"}, 40'(bus.abort_cnt), 40'(0));
`endif
        $display("check: %s outputs at reset values", tag);
    endtask

    initial begin
        rst         = 1'b1;
        bus.bit_in  = 1'b0;
        bus.bit_vld = 1'b0;
        bus.sof     = 1'b0;
        repeat (3) @(posedge clk);
        chk_outputs_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back frames: each new sof lands in the previous frame_vld cycle.
        send(40'h00_00000000, 1'b1, 40, 0);
        send(40'h01_04C11DB7, 1'b1, 40, 0);
        send(40'h01_04C11DB6, 1'b0, 40, 0);
        send(40'h02_09823B6E, 1'b1, 40, 0);   // x^33 mod P = P << 1
        send(40'h00_00000001, 1'b0, 40, 0);
        idle(4);
        @(negedge clk);
        chk("hold_crc_ok",  40'(bus.crc_ok),  40'(last_ok));
        chk("hold_crc_err", 40'(bus.crc_err), 40'(!last_ok));
        chk("hold_msg_out", 40'(bus.msg_out), 40'(last_msg));
        chk("hold_crc_rx",  40'(bus.crc_rx),  40'(last_crc));
        @(posedge clk);
        #1;

        // Non-sof bits while idle are ignored.
        for (int i = 0; i < 6; i++) drive_bit(1'(i), 1'b0);
        @(negedge clk);
        chk("idle_bits_busy", 40'(bus.busy), 40'(0));
        @(posedge clk);
        #1;
        send(40'h01_04C11DB7, 1'b1, 40, 3);

        // sof at bit 20 restarts the frame.
        send(40'h01_04C11DB7, 1'b1, 20, 0);
        @(negedge clk);
        chk("partial_busy", 40'(bus.busy), 40'(1));
        @(posedge clk);
        #1;
        send(40'h01_04C11DB7, 1'b1, 40, 0);

        // sof on what would be the 40th bit wins over completion.
        send(40'h02_09823B6E, 1'b1, 39, 0);
        send(40'h01_04C11DB7, 1'b1, 40, 1);
        idle(3);

`ifdef CRC32_FRAME_RX_ERRCNT_EN
        @(negedge clk);
        chk("err_cnt",   40'(bus.err_cnt),   40'(exp_errcnt));
        chk("abort_cnt", 40'(bus.abort_cnt), 40'(exp_abortcnt));
        @(posedge clk);
        #1;
`endif

        // Reset in the middle of a frame.
        send(40'h02_09823B6E, 1'b1, 30, 0);
        rst          = 1'b1;
        in_frame     = 1'b0;
        tb_cnt       = 0;
        exp_errcnt   = 0;
        exp_abortcnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_outputs_reset("mid_frame_rst");
        @(posedge clk);
        #1;
        send(40'h01_04C11DB7, 1'b1, 40, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_events: %0d events outstanding, expected 0", sb.size());
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/crc32_frame_rx.md
Name: crc32_frame_rx

Overview:
- Receive-side stage directly downstream of the CRC-32 transmit generator.
- Accepts the transmitted frame {msg[7:0], crc[31:0]} as an MSB-first serial bit stream.
- Recomputes the CRC bit-serially with the same plain polynomial division: no init value, no reflection, no final XOR.
- Presents the recovered message with a pass/fail verdict, one frame at a time.

Parameters:
- MSG_W, 8, message bits per frame.
- CRC_W, 32, CRC bits per frame.
- POLY, 32'h04C11DB7, generator polynomial without the implicit x^32 term (the full key is 0x104C11DB7).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- bit_in  in  1  serial frame bit, MSB of msg first.
- bit_vld  in  1  bit_in is valid this cycle; gaps between valid bits are allowed.
- sof  in  1  qualified by bit_vld; marks bit_in as frame bit 0.
- busy  out  1  high while a frame is partially received.
- frame_vld  out  1  one-cycle pulse when a complete frame has been checked.
- msg_out  out  MSG_W  received message; held until the next frame_vld.
- crc_rx  out  CRC_W  received CRC field; held until the next frame_vld.
- crc_ok  out  1  frame remainder is zero; valid with frame_vld and held afterwards.
- crc_err  out  1  complement of crc_ok; valid with frame_vld and held afterwards.
- abort  out  1  one-cycle pulse when a partial frame is discarded by a new sof.

Behaviour:
- Reset values: busy=0, frame_vld=0, abort=0, msg_out=0, crc_rx=0, crc_ok=0, crc_err=0. Internally: state=IDLE, bit counter=0, LFSR=0, shift register=0.
- States: IDLE and SHIFT.
- IDLE:
  - Valid bits with sof=0 are ignored.
  - bit_vld&sof: load the bit as bit 0, set count=1, go to SHIFT.
- SHIFT:
  - Each bit_vld shifts bit_in into a (MSG_W+CRC_W)-bit shift register and steps the LFSR.
  - LFSR step: fb=lfsr[31]^bit_in; lfsr={lfsr[30:0],0} ^ (fb ? POLY : 0).
  - The LFSR restarts from 0 on every sof.
- Frame completion:
  - The bit accepted with count==MSG_W+CRC_W-1 completes the frame and returns the FSM to IDLE.
  - On the next cycle: frame_vld=1; msg_out and crc_rx are loaded from the shift register.
  - crc_ok=1 iff the post-step LFSR == 0; crc_err=~crc_ok.
  - Latency: exactly 1 cycle from the last valid bit to frame_vld.
- sof in SHIFT (count 1..39): the partial frame is discarded.
  - abort pulses on the next cycle.
  - The sof bit becomes bit 0 of the new frame; count=1.
  - No frame_vld is produced for the discarded frame.
- sof on what would be the 40th bit: sof wins. The old frame is aborted, not checked.
- A bit_vld in the same cycle as a frame_vld pulse is legal and is handled normally, including a new sof.
- busy = (state==SHIFT).
- rst asserted mid-frame: all state returns to reset values on the next edge, with no frame_vld and no abort.
- The verdict outputs hold their values between frames.

Optional Feature:
- Macro: CRC32_FRAME_RX_ERRCNT_EN.
- Defined:
  - Adds output err_cnt[15:0], which counts frame_vld&crc_err events.
  - Adds output abort_cnt[15:0], which counts abort pulses.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Package crc32_pkg: CRC_POLY=32'h04C11DB7, MSG_W=8, CRC_W=32, FRAME_W=40, and a state enum {IDLE, SHIFT}.
- The transmit generator shares the same constants from this package.
- Sub-module crc32_serial_lfsr:
  - Inputs: clk, rst, clr, en, din.
  - Output: lfsr[31:0].
  - Provides the single-bit step above, with clr taking priority over en.

Test Plan:
- Frame 40'h00_00000000 sent with sof on bit 0 and bit_vld continuous -> frame_vld after the 40th bit +1 cycle; msg_out=8'h00, crc_rx=0, crc_ok=1.
- Frame 40'h01_04C11DB7 -> msg_out=8'h01, crc_rx=32'h04C11DB7, crc_ok=1, crc_err=0.
- Same frame with bit 0 of the CRC flipped (40'h01_04C11DB6) -> crc_ok=0, crc_err=1. With ERRCNT_EN defined, err_cnt increments to 1.
- Frame 40'h01_04C11DB7 with random bit_vld gaps, and bits with sof=0 preceding the frame while IDLE -> same result as the gap-free case; the pre-frame bits are ignored.
- sof reasserted at bit 20, followed by a full valid frame 40'h01_04C11DB7 -> abort pulse one cycle after bit 20, exactly one frame_vld, crc_ok=1.
- rst pulsed at bit 30 of a frame -> no frame_vld or abort; busy=0 after the next edge; outputs at reset values; the next full frame checks correctly.
